// File: rtl/wb_reg_file_if.sv
// Write-back bundle and decode read ports of the register file.
// master: MEM/WB stage plus decode (drives the commit bundle and the read indices).
// slave:  wb_reg_file (returns read data, the selected write-back data and debug state).
interface wb_reg_file_if #(
   parameter int CNT_W = 16
);
   logic [1:0]       WB_WB;
   logic [31:0]      RD_WB;
   logic [31:0]      ADDR_WB;
   logic [4:0]       WN_WB;
   logic [4:0]       RN1;
   logic [4:0]       RN2;
   logic [31:0]      RD1;
   logic [31:0]      RD2;
   logic [31:0]      WD_WB;
   logic [31:0]      Dirty;
   logic [CNT_W-1:0] WCount;

   modport master (
      output WB_WB, RD_WB, ADDR_WB, WN_WB, RN1, RN2,
      input  RD1, RD2, WD_WB, Dirty, WCount
   );

   modport slave (
      input  WB_WB, RD_WB, ADDR_WB, WN_WB, RN1, RN2,
      output RD1, RD2, WD_WB, Dirty, WCount
   );
endinterface

// File: rtl/wb_reg_file.sv
// Write-back stage register file: selects write-back data, commits it into a
// 32 x 32 architectural register file (r0 hardwired to zero), serves two
// combinational decode read ports, and keeps a written-since-reset mask and
// a saturating commit counter.
// Optional feature: define WB_BYPASS_EN to forward the value being committed
// to a read port that addresses the same (nonzero) register in the same cycle.
module wb_reg_file #(
   parameter int NREG  = 32,
   parameter int CNT_W = 16
) (
   input logic            Clk,
   input logic            Rst,
   wb_reg_file_if.slave   bus
);

   logic [31:0]      regs [NREG];
   logic [NREG-1:0]  dirty;
   logic [CNT_W-1:0] wcount;
   logic [31:0]      wd;
   logic             commit;
   logic             bypass1;
   logic             bypass2;

   // Write-back data select and commit qualification; r0 writes and reset cycles never commit.
   always_comb begin
      wd     = bus.WB_WB[0] ? bus.RD_WB : bus.ADDR_WB;
      commit = bus.WB_WB[1] && (bus.WN_WB != 5'd0) && !Rst;
   end

   // Same-cycle forwarding decision per read port; commit already excludes r0 and reset.
   always_comb begin
`ifdef WB_BYPASS_EN
      bypass1 = commit && (bus.RN1 == bus.WN_WB);
      bypass2 = commit && (bus.RN2 == bus.WN_WB);
`else
      bypass1 = 1'b0;
      bypass2 = 1'b0;
`endif
   end

   // Register array update: reset clears everything and wins over a simultaneous commit.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (commit) begin
         regs[bus.WN_WB] <= wd;
      end
   end

   // Written-since-reset mask; bit 0 can never be set because r0 never commits.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         dirty <= '0;
      end else if (commit) begin
         dirty[bus.WN_WB] <= 1'b1;
      end
   end

   // Saturating commit counter: holds at all-ones instead of wrapping.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wcount <= '0;
      end else if (commit && (wcount != {CNT_W{1'b1}})) begin
         wcount <= wcount + 1'b1;
      end
   end

   // Read ports: r0 reads as zero, otherwise forwarded data or array contents.
   always_comb begin
      if (bus.RN1 == 5'd0) begin
         bus.RD1 = '0;
      end else if (bypass1) begin
         bus.RD1 = wd;
      end else begin
         bus.RD1 = regs[bus.RN1];
      end
      if (bus.RN2 == 5'd0) begin
         bus.RD2 = '0;
      end else if (bypass2) begin
         bus.RD2 = wd;
      end else begin
         bus.RD2 = regs[bus.RN2];
      end
   end

   assign bus.WD_WB  = wd;
   assign bus.Dirty  = dirty;
   assign bus.WCount = wcount;

endmodule

// File: doc/wb_reg_file.md
# wb_reg_file

Write-back end of the MEM/WB pipeline interface: it consumes the registered write-back bundle and commits it into a 32-entry, 32-bit architectural register file. It also selects the write-back data (memory read data or ALU result) and serves the two decode-stage read ports. It keeps a written-since-reset mask and a commit counter for debug and verification. It sits between the MEM/WB pipeline register and the ID stage.

## Interface

- NREG, 32, number of architectural registers (fixed at 32; index width 5)
- CNT_W, 16, width of the commit counter
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- WB_WB  in  2  bit1 = RegWrite, bit0 = MemtoReg
- RD_WB  in  32  memory read data from MEM/WB
- ADDR_WB  in  32  ALU result from MEM/WB
- WN_WB  in  5  destination register number
- RN1  in  5  read port 1 register number
- RN2  in  5  read port 2 register number
- RD1  out  32  read port 1 data (combinational)
- RD2  out  32  read port 2 data (combinational)
- WD_WB  out  32  selected write-back data (combinational)
- Dirty  out  32  bit i = 1 once register i has been committed since reset
- WCount  out  CNT_W  number of committed writes since reset, saturating

## Operation

- WD_WB = RD_WB when WB_WB[0]=1, else ADDR_WB. It is driven regardless of RegWrite.
- Commit condition: WB_WB[1]=1 and WN_WB != 0 and Rst=0.
- On commit at a rising edge: reg[WN_WB] <= WD_WB; Dirty[WN_WB] <= 1; WCount increments by 1.
- WCount saturates at 2^CNT_W-1. At saturation it holds that value and does not wrap.
- Register 0 is hardwired to zero:
  - a write to WN_WB=0 is discarded;
  - it does not set Dirty[0] and does not increment WCount;
  - Dirty[0] is always 0.
- Reads: RDn = 0 when RNn = 0, otherwise reg[RNn]. Bypass behaviour is covered under Configuration.
- Both read ports are independent. RN1 = RN2 is legal and returns identical data on both.
- Consecutive commits to the same register are legal. The last commit wins, and each one increments WCount.

## Timing

- Reset (Rst high at a rising edge): all 31 writable registers <= 0, Dirty <= 0, WCount <= 0.
- Rst has priority over a simultaneous commit. The write is dropped and not counted.
- Reset asserted mid-stream clears all state at that edge. Commits resume on the first edge with Rst low.
- While Rst is high, reads return array contents (pre-reset values until the edge) and bypass is disabled.
- Commit latency: array contents, Dirty and WCount reflect a commit one edge after it is presented.
- Read latency: zero. RD1/RD2/WD_WB are purely combinational from inputs and state.
- No handshake. The block accepts one commit every cycle with no backpressure.

## Configuration

- Macro WB_BYPASS_EN controls same-cycle write-to-read forwarding.
- Defined: when the commit condition holds and RNn = WN_WB (nonzero), RDn = WD_WB in the same cycle. Decode sees the value being written with no extra forwarding path.
- Undefined: RDn always reads the array. A value being committed becomes visible on the read ports only in the cycle after its edge, and the hazard unit must cover the one-cycle gap.
- Register 0 never bypasses in either build.
- Dirty, WCount and the reset behaviour are identical in both builds.

## Test plan

- Reset then idle:
  - stimulus: Rst=1 for 2 cycles, then RN1=5, RN2=31;
  - response: RD1=RD2=0, Dirty=0, WCount=0.
- ALU and memory write-back:
  - stimulus: WB_WB=2'b10, ADDR_WB=0x0000_1234, WN_WB=3, then WB_WB=2'b11, RD_WB=0xDEAD_BEEF, WN_WB=4;
  - response: next cycle RN1=3 gives 0x1234 and RN2=4 gives 0xDEADBEEF; Dirty=0x18; WCount=2.
- Register 0 and disabled writes:
  - stimulus: WB_WB=2'b10, WN_WB=0, ADDR_WB=0xFFFF_FFFF, then WB_WB=2'b00, WN_WB=7;
  - response: RN1=0 gives 0, reg7 unchanged at 0, Dirty=0, WCount=0.
- Same-cycle read of the register being written:
  - stimulus: reg9=0x11, commit ADDR_WB=0x22 to WN_WB=9 with RN1=RN2=9 in the same cycle;
  - response: RD1=RD2=0x22 with WB_BYPASS_EN, 0x11 without it; 0x22 in both builds the next cycle.
- Reset beats commit:
  - stimulus: Rst=1 and a commit of 0x55 to reg 12 on the same edge;
  - response: reg12=0, Dirty[12]=0, WCount=0.
- Counter saturation:
  - stimulus: CNT_W=4, 20 back-to-back commits to reg 1;
  - response: WCount reaches 15 and holds; reg1 holds the last written value.
